reg_decr_pipe: RTL and testbench
================================

REG_DECR_PIPE -- requirements
Module: reg_decr_pipe

Interface
REQ-001 Parameter nbits, default 8, data width of in_msg/out_msg.
REQ-002 Parameter nstages, default 2, number of pipeline stages (legal range 1..8).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 in_val  input  1  producer asserts when in_msg is valid.
REQ-006 in_rdy  output  1  block can accept in_msg this cycle.
REQ-007 in_msg  input  nbits  operand to decrement.
REQ-008 out_val  output  1  out_msg is valid.
REQ-009 out_rdy  input  1  consumer can accept out_msg this cycle.
REQ-010 out_msg  output  nbits  result, in_msg minus nstages, modulo 2^nbits.
REQ-011 count  output  $clog2(nstages+1)  number of valid messages currently held in the pipeline.

Function
REQ-012 The block SHALL hold one register per stage (nbits data, 1 valid bit); stage i+1 is downstream of stage i.
REQ-013 Each stage SHALL subtract 1 from the message on entry, so a message leaving the last stage equals in_msg - nstages.
REQ-014 Arithmetic SHALL be unsigned and nbits wide; 0 - 1 wraps to 2^nbits - 1, with no borrow output.
REQ-015 A transfer SHALL occur only on a cycle where val and rdy are both high on the same port; there is no other acceptance condition.
REQ-016 Last stage advance = valid[last] && out_rdy.
REQ-017 Stage i < last advance = valid[i] && (!valid[i+1] || advance[i+1]).
REQ-018 in_rdy SHALL be !valid[0] || advance[0]: a combinational ready chain, with full throughput and no bubble insertion.
REQ-019 A stage that is valid and not advancing SHALL hold its data and valid bit unchanged (stall).
REQ-020 A stage SHALL load from upstream when upstream advances, and SHALL clear its valid bit when it advances and upstream does not.
REQ-021 Latency: a message accepted in cycle t SHALL first present out_val=1 in cycle t+nstages if no stall occurs.
REQ-022 Throughput SHALL be one message per cycle when out_rdy is held high.
REQ-023 out_val SHALL equal valid[last], and out_msg SHALL equal data[last].
REQ-024 out_val and out_msg SHALL NOT depend combinationally on in_val or in_msg.
REQ-025 Order SHALL be strictly preserved; no message is dropped or duplicated.
REQ-026 count SHALL equal the popcount of the valid bits.
REQ-027 Simultaneous enqueue and dequeue when the pipeline is full SHALL be permitted, with count unchanged.
REQ-028 in_val=1 with in_rdy=0 SHALL have no effect on state.
REQ-029 A non-synthesis line trace SHALL show in_msg, each stage's content ("." when invalid), and out_msg.

Reset
REQ-030 While reset=1 at a posedge, every valid bit and every data register SHALL clear to 0.
REQ-031 After reset: out_val=0, out_msg=0, count=0, and in_rdy=1 in the first cycle after reset deasserts.
REQ-032 Reset mid-operation SHALL discard all in-flight messages, and no out_val SHALL appear for them afterwards.
REQ-033 A handshake coinciding with a reset cycle SHALL be ignored.

Verification (nstages=2, nbits=8)
REQ-034 Streaming: send 0x05, 0x10, 0xFF on consecutive cycles with out_rdy=1 -> outputs 0x03, 0x0E, 0xFD on consecutive cycles, the first 2 cycles after its send.
REQ-035 Wrap: send 0x00 then 0x01 -> outputs 0xFE then 0xFF.
REQ-036 Backpressure: hold out_rdy=0 and send 0x20, 0x21, 0x22 -> the first two are accepted, count=2, and in_rdy=0 for the third; raise out_rdy -> 0x1E, 0x1F, 0x20 emerge in order with nothing lost.
REQ-037 Full pass-through: pipeline full, out_rdy=1, in_val=1 with 0x40 -> in_rdy=1, count stays 2, and 0x3E appears 2 cycles later.
REQ-038 Reset mid-stream: 2 messages in flight, assert reset for 1 cycle -> out_val=0, count=0, and no stale output appears in the next 4 cycles.
REQ-039 Random: random in_val/out_rdy over 1000 messages -> the output sequence equals the input sequence each minus 2 mod 256, and count never exceeds 2.

Source files
------------

// File: rtl/reg_decr_pipe.sv
// Elastic pipeline that subtracts one per stage, so each message leaves as in_msg - nstages.
// Valid/ready handshake on both ports, with a combinational ready chain for full throughput.
module reg_decr_pipe #(
  parameter int nbits   = 8,
  parameter int nstages = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_val,
  output logic                           in_rdy,
  input  logic [nbits-1:0]               in_msg,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [nbits-1:0]               out_msg,
  output logic [$clog2(nstages+1)-1:0]   count
);

  localparam int count_w = $clog2(nstages + 1);
  localparam logic [nbits-1:0] dec_one = nbits'(1);

  logic [nstages-1:0] valid_q;
  logic [nbits-1:0]   data_q [nstages];
  logic [nstages-1:0] adv;
  logic               in_fire;

  // Advance is resolved from the output end backwards: a stage may move on
  // if its successor is empty or is itself moving on this cycle.
  always_comb begin
    logic nxt;
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    adv = '0;
    nxt = valid_q[nstages-1] && out_rdy;
    adv[nstages-1] = nxt;
    for (int i = nstages - 2; i >= 0; i--) begin
      nxt    = valid_q[i] && (!valid_q[i+1] || nxt);
      adv[i] = nxt;
    end
  end

  assign in_rdy  = !valid_q[0] || adv[0];
  assign in_fire = in_val && in_rdy;
  assign out_val = valid_q[nstages-1];
  assign out_msg = data_q[nstages-1];

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every stage
    // samples its upstream neighbour's value from before this edge.
    if (reset) begin
      valid_q <= '0;
      // NOTE: the data registers are cleared too, because out_msg must read
      // zero straight after reset rather than whatever was in flight.
      for (int i = 0; i < nstages; i++) data_q[i] <= '0;
    end else begin
      if (in_fire) begin
        valid_q[0] <= 1'b1;
        data_q[0]  <= in_msg - dec_one;
      end else if (adv[0]) begin
        valid_q[0] <= 1'b0;
      end
      for (int i = 1; i < nstages; i++) begin
        if (adv[i-1]) begin
          valid_q[i] <= 1'b1;
          data_q[i]  <= data_q[i-1] - dec_one;
        end else if (adv[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < nstages; i++) count = count + count_w'(valid_q[i]);
  end

`ifndef SYNTHESIS
  // Printable snapshot: input | each stage ("." when empty) | output.
  function automatic string line_trace();
    string s;
    s = $sformatf("%h |", in_msg);
    for (int i = 0; i < nstages; i++) begin
      if (valid_q[i]) s = {s, $sformatf(" %h", data_q[i])};
      else            s = {s, " ."};
    end
    if (out_val) s = {s, $sformatf(" | %h", out_msg)};
    else         s = {s, " | ."};
    return s;
  endfunction
`endif

endmodule

// File: tb/tb_reg_decr_pipe.sv
// Directed vector table plus a randomized scoreboard run for reg_decr_pipe (nbits=8, nstages=2).
module tb_reg_decr_pipe;

  logic       clk;
  logic       reset;
  logic       in_val;
  logic       in_rdy;
  logic [7:0] in_msg;
  logic       out_val;
  logic       out_rdy;
  logic [7:0] out_msg;
  logic [1:0] count;

  int total;
  int bad;

  reg_decr_pipe #(.nbits(8), .nstages(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] im;
    logic       ordy;
    logic       chk_rdy;
    logic       e_rdy;
    logic       e_oval;
    logic [7:0] e_omsg;
    logic [1:0] e_cnt;
  } vec_t;

  localparam int n_vecs = 23;
  vec_t vecs [n_vecs];

  initial begin
    logic [7:0] exp_q [$];
    int sent, rcvd, cycles;
    logic in_fire, out_fire;
    logic [7:0] exp_msg;

    total = 0;
    bad   = 0;

    //          rst   iv    im     ordy  chkrdy erdy  eoval eomsg  ecnt
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
    vecs[1]  = '{1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    vecs[2]  = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'd1};
    vecs[3]  = '{1'b0, 1'b1, 8'h10, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 2'd2};
    vecs[4]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0E, 2'd2};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFD, 2'd2};
    vecs[6]  = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFE, 2'd2};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 2'd1};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 2'd0};
    vecs[9]  = '{1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 2'd1};
    vecs[10] = '{1'b0, 1'b1, 8'h21, 1'b0, 1'b1, 1'b1, 1'b1, 8'h1E, 2'd2};
    vecs[11] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1E, 2'd2};
    vecs[12] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 8'h1F, 2'd2};
    vecs[13] = '{1'b0, 1'b1, 8'h40, 1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 2'd2};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h3E, 2'd1};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3E, 2'd0};
    vecs[16] = '{1'b0, 1'b1, 8'h50, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3E, 2'd1};
    vecs[17] = '{1'b0, 1'b1, 8'h51, 1'b0, 1'b1, 1'b1, 1'b1, 8'h4E, 2'd2};
    vecs[18] = '{1'b1, 1'b1, 8'h52, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    vecs[21] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    vecs[22] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};

    // Directed table: apply inputs, check the ready chain, clock, check state.
    for (int i = 0; i < n_vecs; i++) begin
      reset   = vecs[i].rst;
      in_val  = vecs[i].iv;
      in_msg  = vecs[i].im;
      out_rdy = vecs[i].ordy;
      #1;
      if (vecs[i].chk_rdy) check($sformatf("v%0d in_rdy", i), 32'(in_rdy), 32'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      $display("trace %0d: %s", i, dut.line_trace());
      check($sformatf("v%0d out_val", i), 32'(out_val), 32'(vecs[i].e_oval));
      check($sformatf("v%0d out_msg", i), 32'(out_msg), 32'(vecs[i].e_omsg));
      check($sformatf("v%0d count", i),   32'(count),   32'(vecs[i].e_cnt));
    end

    // Random traffic against a scoreboard queue of expected outputs.
    reset  = 1'b1;
    in_val = 1'b0;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    sent   = 0;
    rcvd   = 0;
    cycles = 0;
    while (rcvd < 1000 && cycles < 20000) begin
      in_val  = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_msg  = 8'($urandom_range(0, 255));
      out_rdy = 1'($urandom_range(0, 1));
      #1;
      if (count !== 2'(exp_q.size()) || count > 2'd2)
        check("rand count", 32'(count), 32'(exp_q.size()));
      in_fire  = in_val && in_rdy;
      out_fire = out_val && out_rdy;
      if (out_val && exp_q.size() == 0) begin
        check("rand spurious out_val", 32'(out_val), 32'd0);
      end else if (out_fire) begin
        exp_msg = exp_q.pop_front();
        check("rand out_msg", 32'(out_msg), 32'(exp_msg));
        rcvd++;
      end
      if (in_fire) begin
        exp_q.push_back(in_msg - 8'd2);
        sent++;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    check("rand all received", 32'(rcvd), 32'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
